coax_rx_buffer: RTL and testbench

- Receive-side frame buffer. Sits directly downstream of the coax receiver and upstream of the host interface.
- Captures each received 10-bit word and marks the last word of every frame with an end-of-frame flag.
- Converts receiver error conditions into tagged error words.
- Presents everything to the host through a first-word-fall-through FIFO with a pop strobe, an occupancy count and a sticky overflow flag.

---
 rtl/coax_rx_buffer.sv | 165 ++++++++++++++++
 tb/tb_coax_rx_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_rx_buffer.sv
// Receive-side frame buffer: tags end-of-frame and error words from the coax receiver
// and queues them for the host in a first-word-fall-through FIFO.
module coax_rx_buffer #(
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_active,
   input  logic                  rx_error,
   input  logic                  rx_strobe,
   input  logic [9:0]            rx_data,
   input  logic                  read_strobe,
   input  logic                  clear_overflow,
   output logic [15:0]           data_out,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;

   typedef enum logic [1:0] {
      StIdle,
      StReceive,
      StErrorWrite,
      StErrorWait
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  hold_q, hold_d;
   logic        hold_valid_q, hold_valid_d;
   logic [9:0]  code_q, code_d;

   logic        push;
   logic [15:0] push_word;

   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  overflow_q;
   logic [15:0]           mem [Depth];

   logic push_ok;
   logic pop;

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         code_q       <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         code_q       <= code_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      code_d       = code_q;
      push         = 1'b0;
      push_word    = '0;

      case (state_q)
         StIdle: begin
            if (rx_error) begin
               code_d  = rx_data;
               state_d = StErrorWrite;
            end else if (rx_active) begin
               hold_valid_d = 1'b0;
               state_d      = StReceive;
            end
         end

         StReceive: begin
            if (rx_error) begin
               // Flush the held word untagged; the error word follows next cycle.
               push         = hold_valid_q;
               push_word    = {6'b000000, hold_q};
               code_d       = rx_data;
               hold_valid_d = 1'b0;
               state_d      = StErrorWrite;
            end else if (rx_strobe) begin
               push         = hold_valid_q;
               push_word    = {6'b000000, hold_q};
               hold_d       = rx_data;
               hold_valid_d = 1'b1;
            end else if (!rx_active) begin
               push         = hold_valid_q;
               push_word    = {2'b01, 4'b0000, hold_q};
               hold_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end

         StErrorWrite: begin
            push         = 1'b1;
            push_word    = {2'b11, 4'b0000, code_q};
            hold_valid_d = 1'b0;
            state_d      = StErrorWait;
         end

         StErrorWait: begin
            if (!rx_error && !rx_active) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   // count never exceeds Depth, so its MSB alone marks the full condition.
   assign full     = count_q[DEPTH_LOG2];
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign data_out = mem[rd_ptr_q];

   assign push_ok = push && !full;
   assign pop     = read_strobe && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push && full) begin
            overflow_q <= 1'b1;
         end else if (clear_overflow) begin
            overflow_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= push_word;
      end
   end

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Self-checking bench for coax_rx_buffer: directed frame/error/overflow scenarios plus
// randomized frames scored against a frame-level queue of expected host words.
module tb_coax_rx_buffer;

   localparam int unsigned DL = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_active, rx_error, rx_strobe;
   logic [9:0]  rx_data;
   logic        read_strobe, clear_overflow;
   logic [15:0] data_out;
   logic        empty, full, overflow;
   logic [DL:0] count;

   int nvec = 0;
   int nerr = 0;

   logic [15:0] expq[$];
   logic [15:0] gotq[$];
   int          pop_pct;
   int          maxcnt;

   always #5 clk = ~clk;

   coax_rx_buffer #(.DEPTH_LOG2(DL)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_active     (rx_active),
      .rx_error      (rx_error),
      .rx_strobe     (rx_strobe),
      .rx_data       (rx_data),
      .read_strobe   (read_strobe),
      .clear_overflow(clear_overflow),
      .data_out      (data_out),
      .empty         (empty),
      .full          (full),
      .count         (count),
      .overflow      (overflow)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rx_active      = 1'b0;
      rx_error       = 1'b0;
      rx_strobe      = 1'b0;
      rx_data        = '0;
      read_strobe    = 1'b0;
      clear_overflow = 1'b0;
   endtask

   task automatic pop(output logic [15:0] w);
      w           = data_out;
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
   endtask

   // One clock with a random pop; popped words are collected for later scoring.
   task automatic cycle();
      if (!empty && ($urandom_range(99) < pop_pct)) begin
         gotq.push_back(data_out);
         read_strobe = 1'b1;
      end else begin
         read_strobe = 1'b0;
      end
      step();
      read_strobe = 1'b0;
      if (int'(count) > maxcnt) maxcnt = int'(count);
   endtask

   // Drives one frame of n words (optionally aborted by an error) and queues the
   // host words it must produce.
   task automatic send_frame(input int n, input bit err, input logic [9:0] code, input bit b2b);
      logic [9:0] w;
      rx_active = 1'b1;
      rx_error  = 1'b0;
      rx_strobe = 1'b0;
      cycle();
      for (int i = 0; i < n; i++) begin
         if (!b2b) begin
            repeat ($urandom_range(2)) begin
               rx_strobe = 1'b0;
               rx_data   = 10'($urandom);
               cycle();
            end
         end
         w         = 10'($urandom);
         rx_strobe = 1'b1;
         rx_data   = w;
         if (!err && (i == n - 1) && ($urandom_range(1) == 1)) rx_active = 1'b0;
         if (err || (i != n - 1)) expq.push_back({6'b000000, w});
         else expq.push_back({6'b010000, w});
         cycle();
      end
      rx_strobe = 1'b0;
      if (err) begin
         rx_error = 1'b1;
         rx_data  = code;
         expq.push_back({6'b110000, code});
         repeat ($urandom_range(1, 3)) cycle();
         rx_error  = 1'b0;
         rx_active = 1'b1;
         repeat ($urandom_range(2)) cycle();
         rx_active = 1'b0;
         repeat (2) cycle();
      end else begin
         rx_active = 1'b0;
         cycle();
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b want 1", empty); end
      nvec++; if (full !== 1'b0) begin nerr++; $display("FAIL reset_full: got %b want 0", full); end
      nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", count); end
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_single_frame();
      logic [15:0] exp3 [3];
      logic [15:0] w;
      logic [2:0]  cexp [3];
      logic [9:0]  dat  [3];
      exp3 = '{16'h0155, 16'h02AA, 16'h4001};
      cexp = '{3'd0, 3'd1, 3'd2};
      dat  = '{10'h155, 10'h2AA, 10'h001};
      rx_active = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         rx_strobe = 1'b1;
         rx_data   = dat[i];
         step();
         nvec++;
         if (count !== cexp[i]) begin
            nerr++; $display("FAIL frame_count_%0d: got %0d want %0d", i, count, cexp[i]);
         end
      end
      rx_strobe = 1'b0;
      rx_active = 1'b0;
      step();
      nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL frame_count_end: got %0d want 3", count); end
      for (int i = 0; i < 3; i++) begin
         pop(w);
         nvec++;
         if (w !== exp3[i]) begin nerr++; $display("FAIL frame_word_%0d: got %h want %h", i, w, exp3[i]); end
      end
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL frame_drained: got %b want 1", empty); end
   endtask

   task automatic test_error_mid_frame();
      logic [15:0] w;
      rx_active = 1'b1;
      step();
      rx_strobe = 1'b1;
      rx_data   = 10'h0F0;
      step();
      rx_strobe = 1'b0;
      rx_error  = 1'b1;
      rx_data   = 10'h002;
      repeat (3) step();
      nvec++; if (count !== 3'd2) begin nerr++; $display("FAIL errmid_count: got %0d want 2", count); end
      rx_error  = 1'b0;
      rx_strobe = 1'b1;
      rx_data   = 10'h155;
      step();
      step();
      nvec++; if (count !== 3'd2) begin nerr++; $display("FAIL errmid_wait: got %0d want 2", count); end
      rx_strobe = 1'b0;
      rx_active = 1'b0;
      step();
      pop(w);
      nvec++; if (w !== 16'h00F0) begin nerr++; $display("FAIL errmid_word0: got %h want 00f0", w); end
      pop(w);
      nvec++; if (w !== 16'hC002) begin nerr++; $display("FAIL errmid_word1: got %h want c002", w); end
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL errmid_drained: got %b want 1", empty); end
   endtask

   task automatic test_error_idle();
      logic [15:0] w;
      rx_error = 1'b1;
      rx_data  = 10'h001;
      step();
      rx_error = 1'b0;
      rx_data  = '0;
      step();
      step();
      nvec++; if (count !== 3'd1) begin nerr++; $display("FAIL erridle_count: got %0d want 1", count); end
      pop(w);
      nvec++; if (w !== 16'hC001) begin nerr++; $display("FAIL erridle_word: got %h want c001", w); end
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL erridle_drained: got %b want 1", empty); end
   endtask

   task automatic test_overflow();
      logic [9:0]  wd [6];
      logic [9:0]  a, b;
      logic [15:0] w, exp4 [4];
      for (int i = 0; i < 6; i++) wd[i] = 10'($urandom);
      a = 10'($urandom);
      b = 10'($urandom);
      rx_active = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         rx_strobe = 1'b1;
         rx_data   = wd[i];
         step();
         if (i == 4) begin
            nvec++; if (full !== 1'b1) begin nerr++; $display("FAIL ovf_full: got %b want 1", full); end
            nvec++; if (count !== 3'd4) begin nerr++; $display("FAIL ovf_count4: got %0d want 4", count); end
            nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_early: got %b want 0", overflow); end
         end
      end
      nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set: got %b want 1", overflow); end
      rx_strobe = 1'b0;
      rx_active = 1'b0;
      step();
      nvec++; if (count !== 3'd4) begin nerr++; $display("FAIL ovf_eof_drop: got %0d want 4", count); end
      // Push while full coincident with a pop is still dropped; set beats clear.
      rx_active = 1'b1;
      step();
      rx_strobe = 1'b1;
      rx_data   = a;
      step();
      rx_data        = b;
      clear_overflow = 1'b1;
      pop(w);
      clear_overflow = 1'b0;
      nvec++; if (w !== {6'b000000, wd[0]}) begin nerr++; $display("FAIL ovf_pop0: got %h want %h", w, {6'b000000, wd[0]}); end
      nvec++; if (count !== 3'd3) begin nerr++; $display("FAIL ovf_pushpop_full: got %0d want 3", count); end
      nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
      rx_strobe = 1'b0;
      rx_active = 1'b0;
      step();
      nvec++; if (count !== 3'd4) begin nerr++; $display("FAIL ovf_refill: got %0d want 4", count); end
      exp4 = '{{6'b000000, wd[1]}, {6'b000000, wd[2]}, {6'b000000, wd[3]}, {6'b010000, b}};
      for (int i = 0; i < 4; i++) begin
         pop(w);
         nvec++;
         if (w !== exp4[i]) begin nerr++; $display("FAIL ovf_word_%0d: got %h want %h", i, w, exp4[i]); end
      end
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
      nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL ovf_underflow: got %0d want 0", count); end
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL ovf_empty: got %b want 1", empty); end
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clear: got %b want 0", overflow); end
   endtask

   task automatic test_back_to_back();
      expq.delete();
      gotq.delete();
      maxcnt  = 0;
      pop_pct = 100;
      for (int f = 0; f < 10; f++) send_frame($urandom_range(1, 6), 1'b0, 10'd0, 1'b1);
      repeat (6) cycle();
      nvec++; if (maxcnt > 1) begin nerr++; $display("FAIL b2b_maxcount: got %0d want <=1", maxcnt); end
      nvec++;
      if (gotq.size() != expq.size()) begin
         nerr++; $display("FAIL b2b_size: got %0d want %0d", gotq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
         nvec++;
         if (gotq[i] !== expq[i]) begin nerr++; $display("FAIL b2b_word_%0d: got %h want %h", i, gotq[i], expq[i]); end
      end
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_random();
      expq.delete();
      gotq.delete();
      maxcnt = 0;
      for (int f = 0; f < 40; f++) begin
         pop_pct = $urandom_range(0, 80);
         send_frame($urandom_range(0, 3), ($urandom_range(3) == 0), 10'($urandom), 1'b0);
         pop_pct = 100;
         repeat (6) cycle();
      end
      nvec++; if (maxcnt > 4) begin nerr++; $display("FAIL rand_maxcount: got %0d want <=4", maxcnt); end
      nvec++;
      if (gotq.size() != expq.size()) begin
         nerr++; $display("FAIL rand_size: got %0d want %0d", gotq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
         nvec++;
         if (gotq[i] !== expq[i]) begin nerr++; $display("FAIL rand_word_%0d: got %h want %h", i, gotq[i], expq[i]); end
      end
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rand_overflow: got %b want 0", overflow); end
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL rand_empty: got %b want 1", empty); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] w;
      idle_inputs();
      rx_active = 1'b1;
      step();
      rx_strobe = 1'b1;
      rx_data   = 10'($urandom);
      step();
      rx_data   = 10'($urandom);
      step();
      rx_strobe = 1'b0;
      rx_active = 1'b0;
      reset     = 1'b1;
      step();
      reset = 1'b0;
      nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL rstmid_empty: got %b want 1", empty); end
      nvec++; if (count !== 3'd0) begin nerr++; $display("FAIL rstmid_count: got %0d want 0", count); end
      nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
      step();
      rx_active = 1'b1;
      step();
      rx_strobe = 1'b1;
      rx_data   = 10'h3FF;
      step();
      rx_strobe = 1'b0;
      rx_active = 1'b0;
      step();
      nvec++; if (count !== 3'd1) begin nerr++; $display("FAIL rstmid_newcount: got %0d want 1", count); end
      pop(w);
      nvec++; if (w !== 16'h43FF) begin nerr++; $display("FAIL rstmid_word: got %h want 43ff", w); end
   endtask

   initial begin
      idle_inputs();
      reset   = 1'b1;
      pop_pct = 0;
      maxcnt  = 0;
      test_reset();
      test_single_frame();
      test_error_mid_frame();
      test_error_idle();
      test_overflow();
      test_back_to_back();
      idle_inputs();
      test_random();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
